// File: rtl/timer_ctrl.sv
// timer_ctrl
//   Control block for timer 0 and external interrupts 0/1. Holds the TCON
//   register, generates the machine-cycle prescale tick, applies the
//   TR0/GATE/INT0 run condition toward the timer, captures timer overflow
//   into TF0 and raises interrupt requests with acknowledge-clear handshakes.
//
// Ports
//   clock, reset            system clock, asynchronous active-high reset
//   wr_addr, data_in        SFR byte address (or bit address) and write data
//   wr, wr_bit              write strobe; 1 = bit write, 0 = byte write
//   tmod_gate0              GATE for timer 0 (TMOD[3])
//   tf0_in                  overflow flag from the timer 0 datapath
//   int0_n, int1_n          asynchronous active-low external interrupt pins
//   ack_t0, ack_x0, ack_x1  one-cycle interrupt acknowledges
//   tcon                    {TF1,TR1,TF0,TR0,IE1,IT1,IE0,IT0}
//   t0_tick                 one-cycle count pulse to the timer
//   t0_hold                 count inhibit to the timer
//   irq_t0, irq_x0, irq_x1  interrupt requests (TF0, IE0, IE1)

module timer_ctrl #(
  parameter int PRESCALE = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] wr_addr,
  input  logic [7:0] data_in,
  input  logic       wr,
  input  logic       wr_bit,
  input  logic       tmod_gate0,
  input  logic       tf0_in,
  input  logic       int0_n,
  input  logic       int1_n,
  input  logic       ack_t0,
  input  logic       ack_x0,
  input  logic       ack_x1,
  output logic [7:0] tcon,
  output logic       t0_tick,
  output logic       t0_hold,
  output logic       irq_t0,
  output logic       irq_x0,
  output logic       irq_x1
);

  localparam logic [7:0] SFR_TCON = 8'h88;
  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  // TCON bit positions
  localparam int B_IT0 = 0;
  localparam int B_IE0 = 1;
  localparam int B_IT1 = 2;
  localparam int B_IE1 = 3;
  localparam int B_TR0 = 4;
  localparam int B_TF0 = 5;

  logic [7:0] pre_cnt;
  logic       pre_tick;
  logic       int0_s1, int0_s, int0_d;
  logic       int1_s1, int1_s, int1_d;
  logic       tf0_in_d;
  logic       run0;
  logic       tf0_rise, int0_fall, int1_fall;
  logic       byte_wr, bit_wr;
  logic [7:0] sw_val;
  logic [7:0] tcon_next;

  // Free-running machine-cycle prescaler; software writes never touch it.
  assign pre_tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         pre_cnt <= 8'd0;
    else if (pre_tick) pre_cnt <= 8'd0;
    else               pre_cnt <= pre_cnt + 8'd1;
  end

  // Two-stage synchronizers for the interrupt pins, followed by a register
  // holding the previous synchronized level for falling-edge detection.
  // Everything resets to the idle (high) pin level so no edge is seen
  // coming out of reset. tf0_in_d tracks the overflow flag for its own
  // rising-edge detect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      int0_s1  <= 1'b1;
      int0_s   <= 1'b1;
      int0_d   <= 1'b1;
      int1_s1  <= 1'b1;
      int1_s   <= 1'b1;
      int1_d   <= 1'b1;
      tf0_in_d <= 1'b0;
    end else begin
      int0_s1  <= int0_n;
      int0_s   <= int0_s1;
      int0_d   <= int0_s;
      int1_s1  <= int1_n;
      int1_s   <= int1_s1;
      int1_d   <= int1_s;
      tf0_in_d <= tf0_in;
    end
  end

  assign tf0_rise  = tf0_in & ~tf0_in_d;
  assign int0_fall = int0_d & ~int0_s;
  assign int1_fall = int1_d & ~int1_s;

  // Timer 0 runs when TR0 is set and, with GATE, the synced INT0 pin is high.
  assign run0    = tcon[B_TR0] & (~tmod_gate0 | int0_s);
  assign t0_tick = pre_tick & run0;
  assign t0_hold = ~run0;

  assign byte_wr = wr & ~wr_bit & (wr_addr == SFR_TCON);
  assign bit_wr  = wr &  wr_bit & (wr_addr[7:3] == SFR_TCON[7:3]);

  // Software value first, then hardware events override the flag bits:
  // a set event beats an acknowledge, which beats the software write.
  // In level mode the IE flags simply follow the inverted synced pin.
  always_comb begin
    sw_val = tcon;
    if (byte_wr)     sw_val = data_in;
    else if (bit_wr) sw_val[wr_addr[2:0]] = data_in[0];

    tcon_next = sw_val;

    if (tf0_rise)    tcon_next[B_TF0] = 1'b1;
    else if (ack_t0) tcon_next[B_TF0] = 1'b0;

    if (tcon[B_IT0]) begin
      if (int0_fall)   tcon_next[B_IE0] = 1'b1;
      else if (ack_x0) tcon_next[B_IE0] = 1'b0;
    end else begin
      tcon_next[B_IE0] = ~int0_s;
    end

    if (tcon[B_IT1]) begin
      if (int1_fall)   tcon_next[B_IE1] = 1'b1;
      else if (ack_x1) tcon_next[B_IE1] = 1'b0;
    end else begin
      tcon_next[B_IE1] = ~int1_s;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tcon <= 8'h00;
    else       tcon <= tcon_next;
  end

  assign irq_t0 = tcon[B_TF0];
  assign irq_x0 = tcon[B_IE0];
  assign irq_x1 = tcon[B_IE1];

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl
//   Self-checking bench for timer_ctrl. A behavioural model tracks cycle
//   count since reset, pin history and TCON; directed scenarios are followed
//   by randomized traffic with an asynchronous reset in the middle.

module tb_timer_ctrl;

  localparam int P = 12;

  logic       clock, reset;
  logic [7:0] wr_addr, data_in;
  logic       wr, wr_bit, tmod_gate0, tf0_in, int0_n, int1_n;
  logic       ack_t0, ack_x0, ack_x1;
  logic [7:0] tcon;
  logic       t0_tick, t0_hold, irq_t0, irq_x0, irq_x1;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int         m_cycles;
  logic       m_pin0_hist[$];
  logic       m_pin1_hist[$];
  logic       m_tf_prev;
  logic [7:0] m_tcon;

  timer_ctrl #(.PRESCALE(P)) dut (
    .clock(clock), .reset(reset), .wr_addr(wr_addr), .data_in(data_in),
    .wr(wr), .wr_bit(wr_bit), .tmod_gate0(tmod_gate0), .tf0_in(tf0_in),
    .int0_n(int0_n), .int1_n(int1_n), .ack_t0(ack_t0), .ack_x0(ack_x0),
    .ack_x1(ack_x1), .tcon(tcon), .t0_tick(t0_tick), .t0_hold(t0_hold),
    .irq_t0(irq_t0), .irq_x0(irq_x0), .irq_x1(irq_x1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_cycles    = 0;
    m_pin0_hist = '{1'b1, 1'b1, 1'b1};
    m_pin1_hist = '{1'b1, 1'b1, 1'b1};
    m_tf_prev   = 1'b0;
    m_tcon      = 8'h00;
  endtask

  // Expected {tick, hold, irq_t0, irq_x0, irq_x1}. The synced pin level is
  // the pin value sampled two clock edges earlier (history index 1).
  function automatic logic [4:0] modelOutputs();
    logic run, tick;
    run  = m_tcon[4] && (!tmod_gate0 || m_pin0_hist[1]);
    tick = ((m_cycles % P) == P - 1) && run;
    return {tick, !run, m_tcon[5], m_tcon[1], m_tcon[3]};
  endfunction

  // Advance the model across one clock edge using the current inputs.
  task automatic modelEdge();
    logic [7:0] nxt;
    logic       fall0, fall1, low0, low1;
    low0  = !m_pin0_hist[1];
    low1  = !m_pin1_hist[1];
    fall0 = m_pin0_hist[2] && !m_pin0_hist[1];
    fall1 = m_pin1_hist[2] && !m_pin1_hist[1];
    nxt   = m_tcon;
    if (wr && !wr_bit && wr_addr == 8'h88) nxt = data_in;
    if (wr && wr_bit && wr_addr >= 8'h88 && wr_addr <= 8'h8F) nxt[wr_addr - 8'h88] = data_in[0];
    if (tf0_in && !m_tf_prev) nxt[5] = 1'b1;
    else if (ack_t0)          nxt[5] = 1'b0;
    if (m_tcon[0]) begin
      if (fall0)       nxt[1] = 1'b1;
      else if (ack_x0) nxt[1] = 1'b0;
    end else nxt[1] = low0;
    if (m_tcon[2]) begin
      if (fall1)       nxt[3] = 1'b1;
      else if (ack_x1) nxt[3] = 1'b0;
    end else nxt[3] = low1;
    m_tcon = nxt;
    m_pin0_hist.push_front(int0_n);
    void'(m_pin0_hist.pop_back());
    m_pin1_hist.push_front(int1_n);
    void'(m_pin1_hist.pop_back());
    m_tf_prev = tf0_in;
    m_cycles++;
  endtask

  task automatic checkAgainstModel();
    checkOutput("tcon", {4'h0, tcon}, {4'h0, m_tcon});
    checkOutput("ctl", {7'h0, t0_tick, t0_hold, irq_t0, irq_x0, irq_x1}, {7'h0, modelOutputs()});
  endtask

  // Run one clock cycle with the current input values: check the settled
  // outputs, take the edge, advance the model. Returns 1 ns after the edge.
  task automatic applyStimulus();
    #1;
    checkAgainstModel();
    @(posedge clock);
    modelEdge();
    #1;
  endtask

  task automatic clearStrobes();
    wr = 1'b0; wr_bit = 1'b0; wr_addr = 8'h00; data_in = 8'h00;
    ack_t0 = 1'b0; ack_x0 = 1'b0; ack_x1 = 1'b0;
  endtask

  task automatic sfrWrite(input logic bitw, input logic [7:0] a, input logic [7:0] d);
    wr = 1'b1; wr_bit = bitw; wr_addr = a; data_in = d;
    applyStimulus();
    clearStrobes();
  endtask

  task automatic assertReset();
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("reset_tcon", {4'h0, tcon}, 12'h000);
    checkOutput("reset_ctl", {7'h0, t0_tick, t0_hold, irq_t0, irq_x0, irq_x1}, 12'h008);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  int ticks;

  initial begin
    clearStrobes();
    tmod_gate0 = 1'b0; tf0_in = 1'b0; int0_n = 1'b1; int1_n = 1'b1;
    assertReset();

    // TR0 via bit write, then ticks every P clocks
    sfrWrite(1'b1, 8'h8C, 8'h01);
    checkOutput("tr0_set", {4'h0, tcon}, 12'h010);
    ticks = 0;
    for (int i = 0; i < 2 * P; i++) begin
      #1; ticks += int'(t0_tick);
      applyStimulus();
    end
    checkOutput("tick_count", 12'(ticks), 12'd2);
    checkOutput("hold_running", {11'h0, t0_hold}, 12'h000);

    // GATE with INT0 low stops the timer
    tmod_gate0 = 1'b1; int0_n = 1'b0;
    repeat (3) applyStimulus();
    ticks = 0;
    for (int i = 0; i < P + 2; i++) begin
      #1; ticks += int'(t0_tick);
      applyStimulus();
    end
    checkOutput("gated_ticks", 12'(ticks), 12'd0);
    checkOutput("gated_hold", {11'h0, t0_hold}, 12'h001);
    int0_n = 1'b1;
    repeat (2 * P) applyStimulus();

    // overflow pulse held high: one set, ack clears, no re-set
    tf0_in = 1'b1;
    applyStimulus();
    checkOutput("tf0_set", {4'h0, tcon}, 12'h030);
    applyStimulus();
    ack_t0 = 1'b1; applyStimulus(); ack_t0 = 1'b0;
    repeat (2) applyStimulus();
    checkOutput("tf0_no_reset", {11'h0, irq_t0}, 12'h000);
    tf0_in = 1'b0;
    applyStimulus();

    // set beats ack and software write in the same cycle
    tf0_in = 1'b1; ack_t0 = 1'b1;
    sfrWrite(1'b0, 8'h88, 8'h00);
    checkOutput("tf0_priority", {4'h0, tcon}, 12'h020);
    tf0_in = 1'b0;

    // edge-mode IE0
    sfrWrite(1'b0, 8'h88, 8'h01);
    int0_n = 1'b0;
    repeat (2) applyStimulus();
    checkOutput("ie0_not_yet", {11'h0, irq_x0}, 12'h000);
    applyStimulus();
    checkOutput("ie0_edge", {11'h0, irq_x0}, 12'h001);
    ack_x0 = 1'b1; applyStimulus(); ack_x0 = 1'b0;
    repeat (5) applyStimulus();
    checkOutput("ie0_held_low", {11'h0, irq_x0}, 12'h000);

    // level-mode IE0 ignores software, follows the pin
    sfrWrite(1'b0, 8'h88, 8'h00);
    applyStimulus();
    checkOutput("ie0_level", {11'h0, irq_x0}, 12'h001);
    sfrWrite(1'b1, 8'h89, 8'h00);
    checkOutput("ie0_sw_ignored", {11'h0, irq_x0}, 12'h001);
    int0_n = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("ie0_released", {11'h0, irq_x0}, 12'h000);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      clearStrobes();
      if ($urandom_range(0, 5) == 0) begin
        wr = 1'b1;
        wr_bit = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       wr_addr = 8'h88;
          1, 2:    wr_addr = 8'h88 + 8'($urandom_range(0, 7));
          default: wr_addr = 8'($urandom);
        endcase
        data_in = 8'($urandom);
      end
      if ($urandom_range(0, 5) == 0)  int0_n = ~int0_n;
      if ($urandom_range(0, 5) == 0)  int1_n = ~int1_n;
      if ($urandom_range(0, 7) == 0)  tf0_in = ~tf0_in;
      if ($urandom_range(0, 19) == 0) tmod_gate0 = ~tmod_gate0;
      ack_t0 = ($urandom_range(0, 5) == 0);
      ack_x0 = ($urandom_range(0, 5) == 0);
      ack_x1 = ($urandom_range(0, 5) == 0);
      applyStimulus();
      if (i == 1200) begin
        clearStrobes();
        #2;
        assertReset();
      end
    end
    clearStrobes();
    applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
